// File: rtl/reg_file_bist_if.sv
// Register-file access bus between the BIST initiator (master) and the
// 2R1W register file (slave).
interface reg_file_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  modport master (
    output ra, rb, wa, wd, we,
    input  read_a, read_b
  );

  modport slave (
    input  ra, rb, wa, wd, we,
    output read_a, read_b
  );
endinterface

// File: rtl/reg_file_bist.sv
// Two-pass BIST for a 2-read/1-write register file: write pattern, read back
// on both ports (port B in reverse order), count and capture mismatches.
module reg_file_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic [DATA_W-1:0] fail_data,
  reg_file_bist_if.master   rf
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int CW   = ADDR_W + 1;
  localparam logic [CW-1:0] WRITE_LAST = CW'(NREG - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(NREG - 1 + RD_LAT);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            p_q, p_d;

  logic [ADDR_W-1:0] ra_q, rb_q, wa_q;
  logic [ADDR_W-1:0] ra_dly, rb_dly;
  logic [DATA_W-1:0] wd_q;
  logic              we_q;
  logic              fail_seen;

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_ra, cmp_rb;
  logic              mis_a, mis_b;
  logic [8:0]        err_sum;
  logic [7:0]        err_next;

  function automatic logic [DATA_W-1:0] pat(input logic inv,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = {(DATA_W / ADDR_W){a}};
    return inv ? ~r : r;
  endfunction

  assign rf.ra = ra_q;
  assign rf.rb = rb_q;
  assign rf.wa = wa_q;
  assign rf.wd = wd_q;
  assign rf.we = we_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          idx_d   = '0;
          p_d     = 1'b0;
        end
      end
      WRITE: begin
        if (idx_q == WRITE_LAST) begin
          state_d = READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READ: begin
        if (idx_q == READ_LAST) begin
          if (p_q) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
            p_d     = 1'b1;
            idx_d   = '0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With a registered read the data lags the address by one cycle, so the
  // first READ cycle compares nothing and the delayed addresses are used.
  always_comb begin
    cmp_valid = 1'b0;
    cmp_ra    = ra_q;
    cmp_rb    = rb_q;
    if (state_q == READ) begin
      if (RD_LAT == 0) begin
        cmp_valid = 1'b1;
      end else begin
        cmp_valid = (idx_q != '0);
        cmp_ra    = ra_dly;
        cmp_rb    = rb_dly;
      end
    end
    mis_a    = cmp_valid && (rf.read_a != pat(p_q, cmp_ra));
    mis_b    = cmp_valid && (rf.read_b != pat(p_q, cmp_rb));
    err_sum  = {1'b0, err_count} + {8'd0, mis_a} + {8'd0, mis_b};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
    end
  end

  // Bus outputs are registered from next-state values so they line up with
  // the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      ra_dly <= '0;
      rb_dly <= '0;
    end else begin
      we_q   <= (state_d == WRITE);
      ra_dly <= ra_q;
      rb_dly <= rb_q;
      if (state_d == WRITE) begin
        wa_q <= idx_d[ADDR_W-1:0];
        wd_q <= pat(p_d, idx_d[ADDR_W-1:0]);
      end
      if (state_d == READ && !idx_d[ADDR_W]) begin
        ra_q <= idx_d[ADDR_W-1:0];
        rb_q <= ~idx_d[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_port <= 1'b0;
      fail_data <= '0;
      fail_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            fail_data <= '0;
            fail_seen <= 1'b0;
          end
        end
        READ: begin
          err_count <= err_next;
          if (!fail_seen && (mis_a || mis_b)) begin
            fail_seen <= 1'b1;
            if (mis_a) begin
              fail_addr <= cmp_ra;
              fail_port <= 1'b0;
              fail_data <= rf.read_a;
            end else begin
              fail_addr <= cmp_rb;
              fail_port <= 1'b1;
              fail_data <= rf.read_b;
            end
          end
          if (state_d == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == 8'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
- Built-in self-test initiator that drives the write and dual read ports of the 2-read/1-write register file (Reg_File_2R1W, 16 x 8).
- On `start` it runs two passes. Each pass writes a data pattern to every register, then reads every register back through both read ports at once, port B walking addresses in reverse.
- It counts mismatches, captures the first failure, and reports pass/fail to the ProtoCore debug/status logic.

Parameters:
- ADDR_W, 4, register address width; the block tests 2**ADDR_W registers.
- DATA_W, 8, register data width; must be an integer multiple of ADDR_W.
- RD_LAT, 0, register-file read latency in cycles; only 0 (combinational read) and 1 (registered read) are legal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin test; sampled only in IDLE
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test completion
- pass  out  1  1 = last test had zero mismatches; held until next start
- err_count  out  8  mismatch count, saturates at 255
- fail_addr  out  ADDR_W  register address of first mismatch
- fail_port  out  1  port of first mismatch: 0 = A, 1 = B
- fail_data  out  DATA_W  data read at first mismatch
- ra  out  ADDR_W  read address, port A
- rb  out  ADDR_W  read address, port B
- wa  out  ADDR_W  write address
- wd  out  DATA_W  write data
- we  out  1  write enable
- read_a  in  DATA_W  read data, port A
- read_b  in  DATA_W  read data, port B

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - we, busy, done, pass, err_count, fail_*, ra, rb, wa, wd all go to 0.
- Pattern for address i:
  - pat0(i) = i replicated DATA_W/ADDR_W times (i*8'h11 at default widths).
  - pat1(i) = ~pat0(i).
- FSM states are IDLE, WRITE, READ, DONE. The block tracks a pass bit p and an index idx.
- IDLE:
  - start=1 at a clock edge moves to WRITE with p=0, idx=0.
  - On that same edge: busy=1, err_count=0, pass=0, fail_* cleared.
- WRITE:
  - Drives we=1, wa=idx, wd=pat_p(idx).
  - idx increments each cycle. After idx=2**ADDR_W-1, goes to READ with idx=0.
- READ:
  - Drives we=0, ra=idx, rb=(2**ADDR_W-1)-idx.
  - RD_LAT=0: read_a/read_b are compared in the same cycle against pat_p(ra)/pat_p(rb). The phase lasts 2**ADDR_W cycles.
  - RD_LAT=1: comparison uses the addresses delayed by one cycle. The phase lasts 2**ADDR_W+1 cycles; the first cycle compares nothing.
  - At the end of the phase: p=0 goes to WRITE with p=1, idx=0; p=1 goes to DONE.
- Mismatch handling:
  - Each mismatching port adds 1 to err_count, so both ports mismatching in one cycle adds 2 (saturating).
  - On the first mismatch of a run, fail_addr/fail_port/fail_data are latched. If both ports fail in that cycle, port A wins.
  - Later mismatches do not update fail_*.
- DONE:
  - Lasts one cycle: busy=0, done=1, pass=(err_count==0). Then returns to IDLE.
  - start is ignored in DONE.
- start while busy is ignored; there is no restart mid-run.
- we is 0 in every state except WRITE. wa/wd hold their last values when we=0.
- Busy duration from the start edge to the done pulse:
  - RD_LAT=0: 64 cycles at default widths.
  - RD_LAT=1: 66 cycles at default widths.
- Reset mid-run aborts the run. we drops asynchronously, so no partial write occurs after reset. A subsequent start runs a full fresh test.

Test Plan:
- Fault-free register file model, RD_LAT=0, pulse start: busy high 64 cycles, then done pulse with pass=1 and err_count=0. The bench checks wa/wd sequence 0/00..F/FF, then 0/FF..F/00.
- Register 3 bit 0 stuck-at-0: pass0 reads 0x32 via port A at idx3 and via port B at idx12; pass1 sees no error.
  - Expected: err_count=2, fail_addr=3, fail_port=0, fail_data=0x32, pass=0.
- read_b bus bit 7 stuck-at-1: the first error is at pass0 idx8, rb=7, reading 0xF7.
  - Expected: fail_addr=7, fail_port=1, fail_data=0xF7, err_count=16 (regs 0-7 in pass0, regs 8-15 in pass1).
- RD_LAT=1 with a registered-read fault-free model: busy 66 cycles, pass=1, err_count=0.
- Drive rst_n low during the pass0 READ phase:
  - we, busy and all outputs go to 0 immediately.
  - After release, start runs the full 64 cycles and passes.
- Pulse start repeatedly while busy, and once during DONE: run length unchanged (64), exactly one done pulse, we=0 throughout every READ phase.
